// File: rtl/light_decoder.sv
// light_decoder: recovers the 3-bit {R,G,B} colour code from a 24-bit RGB
// light bus. Transients are filtered by a stability window, and each new
// stable colour is reported once over a valid/ready handshake.
//
// Build option: LIGHT_DECODER_THRESHOLD_EN
//   undefined (default): a channel byte must be exactly 8'h00 or 8'hFF;
//                        anything else raises code_err and forces colour=0.
//   defined:             a channel bit is byte[7]; every value decodes and
//                        code_err stays 0.
//
// Handshake: out_valid rises with a report and stays high, together with
// colour/is_white/code_err, until the clock edge where out_valid and
// out_ready are both high; that edge counts the report and out_valid is low
// in the following cycle. out_ready is ignored while out_valid is low.
module light_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [23:0]      light,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [2:0]       colour,
  output logic             is_white,
  output logic             code_err,
  output logic             overrun,
  output logic [CNT_W-1:0] report_cnt,
  output logic             fsm_state_o
);

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Stability counter width covers the full legal window 1..255.
  localparam logic [7:0] STABLE_MAX = STABLE_CYCLES[7:0];

  // Input register and stability tracking
  logic [23:0] light_q;
  logic [7:0]  stab_cnt_q, stab_cnt_d;
  logic        same_w;
  logic        qual_w;

  // Report bookkeeping
  logic [0:0]  state_q, state_d;
  logic [23:0] last_q, last_d;
  logic        last_vld_q, last_vld_d;
  logic        new_val_w;

  // Output registers
  logic             out_valid_q, out_valid_d;
  logic [2:0]       colour_q, colour_d;
  logic             white_q, white_d;
  logic             err_q, err_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Decoder results for the registered bus value
  logic [2:0] dec_bits;
  logic       dec_err;
  logic [2:0] dec_colour;
  logic       dec_white;

  // Per-channel classification of light_q into a code bit.
  always_comb begin
    dec_bits = 3'b000;
    dec_err  = 1'b0;
`ifdef LIGHT_DECODER_THRESHOLD_EN
    dec_bits = {light_q[23], light_q[15], light_q[7]};
    dec_err  = 1'b0;
`else
    for (int i = 0; i < 3; i++) begin
      if (light_q[8*i +: 8] == 8'hFF) begin
        dec_bits[i] = 1'b1;
      end else if (light_q[8*i +: 8] != 8'h00) begin
        dec_err = 1'b1;
      end
    end
`endif
  end

  // An illegal code reports as colour 0 and can never be white.
  assign dec_colour = dec_err ? 3'b000 : dec_bits;
  assign dec_white  = !dec_err && (dec_bits == 3'b111);

  // The counter compares the live bus with the registered copy so that its
  // next value already reflects the current edge; qualification uses that
  // next value, which puts out_valid on edge STABLE_CYCLES+1 after a change.
  assign same_w = (light == light_q);

  // Next stability count: clear on change, otherwise saturate at the window.
  always_comb begin
    stab_cnt_d = stab_cnt_q;
    if (!same_w) begin
      stab_cnt_d = 8'd0;
    end else if (stab_cnt_q != STABLE_MAX) begin
      stab_cnt_d = stab_cnt_q + 8'd1;
    end
  end

  assign qual_w    = (stab_cnt_d == STABLE_MAX);
  assign new_val_w = !last_vld_q || (light_q != last_q);

  // Report FSM: launch a report in WAIT, freeze it in HOLD until accepted.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    last_vld_d  = last_vld_q;
    out_valid_d = out_valid_q;
    colour_d    = colour_q;
    white_d     = white_q;
    err_d       = err_q;
    overrun_d   = overrun_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (qual_w && new_val_w) begin
          state_d     = ST_HOLD;
          last_d      = light_q;
          last_vld_d  = 1'b1;
          out_valid_d = 1'b1;
          colour_d    = dec_colour;
          white_d     = dec_white;
          err_d       = dec_err;
        end
      end
      ST_HOLD: begin
        // A different value qualifying while a report waits is lost.
        if (qual_w && (light_q != last_q)) begin
          overrun_d = 1'b1;
        end
        if (out_valid_q && out_ready) begin
          state_d     = ST_WAIT;
          out_valid_d = 1'b0;
          cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d     = ST_WAIT;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Input register and stability counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      light_q    <= 24'h000000;
      stab_cnt_q <= 8'd0;
    end else begin
      light_q    <= light;
      stab_cnt_q <= stab_cnt_d;
    end
  end

  // FSM state, last-reported value and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_WAIT;
      last_q      <= 24'h000000;
      last_vld_q  <= 1'b0;
      out_valid_q <= 1'b0;
      colour_q    <= 3'b000;
      white_q     <= 1'b0;
      err_q       <= 1'b0;
      overrun_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      last_vld_q  <= last_vld_d;
      out_valid_q <= out_valid_d;
      colour_q    <= colour_d;
      white_q     <= white_d;
      err_q       <= err_d;
      overrun_q   <= overrun_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign colour      = colour_q;
  assign is_white    = white_q;
  assign code_err    = err_q;
  assign overrun     = overrun_q;
  assign report_cnt  = cnt_q;
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_light_decoder.sv
// Bench for light_decoder: directed scenarios plus randomized bus activity,
// all checked against a reference model built from the colour-code rules.
module tb_light_decoder;

  localparam int S  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [23:0]   light = 24'h000000;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [2:0]    colour;
  logic          is_white;
  logic          code_err;
  logic          overrun;
  logic [CW-1:0] report_cnt;
  logic          fsm_state_o;

  light_decoder #(.STABLE_CYCLES(S), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .light      (light),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .colour     (colour),
    .is_white   (is_white),
    .code_err   (code_err),
    .overrun    (overrun),
    .report_cnt (report_cnt),
    .fsm_state_o(fsm_state_o)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: bus history window, report bookkeeping, expected outputs
  logic [23:0] hist[$];
  bit          m_pending;
  bit          m_last_vld;
  logic [23:0] m_last;
  bit          m_overrun;
  logic [2:0]  m_colour;
  bit          m_white;
  bit          m_err;
  int          m_cnt;

  // Returns {err, R, G, B} for a 24-bit bus value.
  function automatic logic [3:0] decode(input logic [23:0] v);
    logic [2:0] bits;
    logic       err;
    logic [7:0] b;
    bits = 3'b000;
    err  = 1'b0;
    for (int ch = 0; ch < 3; ch++) begin
      b = v[23-8*ch -: 8];
`ifdef LIGHT_DECODER_THRESHOLD_EN
      bits[2-ch] = (b >= 8'h80);
`else
      if (b == 8'hFF) bits[2-ch] = 1'b1;
      else if (b != 8'h00) err = 1'b1;
`endif
    end
    return {err, bits};
  endfunction

  function automatic logic [23:0] code_to_light(input logic [2:0] c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  // Qualified once the last S+1 sampled bus values are all identical.
  function automatic bit qualifies();
    if (hist.size() != S + 1) return 1'b0;
    foreach (hist[i]) if (hist[i] != hist[0]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back(24'h000000);
    m_pending  = 0;
    m_last_vld = 0;
    m_last     = 24'h000000;
    m_overrun  = 0;
    m_colour   = 3'b000;
    m_white    = 0;
    m_err      = 0;
    m_cnt      = 0;
  endtask

  task automatic model_edge(input logic [23:0] l, input logic r);
    bit         q;
    logic [3:0] d;
    hist.push_back(l);
    if (hist.size() > S + 1) void'(hist.pop_front());
    q = qualifies();
    if (m_pending) begin
      if (q && l != m_last) m_overrun = 1;
      if (r) begin
        m_pending = 0;
        m_cnt     = (m_cnt + 1) % (1 << CW);
      end
    end else if (q && (!m_last_vld || l != m_last)) begin
      d          = decode(l);
      m_pending  = 1;
      m_last_vld = 1;
      m_last     = l;
      m_err      = d[3];
      m_colour   = d[3] ? 3'b000 : d[2:0];
      m_white    = !d[3] && (d[2:0] == 3'b111);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_pending});
    chk("report_cnt", {24'd0, report_cnt}, m_cnt);
    chk("overrun", {31'd0, overrun}, {31'd0, m_overrun});
    chk("fsm_state", {31'd0, fsm_state_o}, {31'd0, m_pending});
    if (m_pending) begin
      chk("colour", {29'd0, colour}, {29'd0, m_colour});
      chk("is_white", {31'd0, is_white}, {31'd0, m_white});
      chk("code_err", {31'd0, code_err}, {31'd0, m_err});
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_colour"}, {29'd0, colour}, 0);
    chk({tag, "_white"}, {31'd0, is_white}, 0);
    chk({tag, "_err"}, {31'd0, code_err}, 0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 0);
    chk({tag, "_cnt"}, {24'd0, report_cnt}, 0);
  endtask

  // Driver: called just after an edge; drives, waits one edge, checks.
  task automatic step(input logic [23:0] l, input logic r);
    light     = l;
    out_ready = r;
    @(posedge clk);
    model_edge(l, r);
    #1 check_all();
  endtask

  task automatic hold(input logic [23:0] l, input logic r, input int n);
    for (int i = 0; i < n; i++) step(l, r);
  endtask

  task automatic apply_reset(input logic [23:0] l);
    @(negedge clk);
    rst       = 1'b0;
    light     = l;
    out_ready = 1'b0;
    #1 model_reset();
    check_zero("rst_async");
    repeat (3) @(posedge clk);
    #1 check_zero("rst_held");
    rst = 1'b1;
  endtask

  function automatic logic [23:0] pick_light();
    int unsigned r;
    logic [23:0] v;
    r = $urandom_range(0, 9);
    if (r < 8) return code_to_light(r[2:0]);
    if (r == 8) return 24'($urandom);
    v = code_to_light(3'($urandom_range(0, 7)));
    v[8*$urandom_range(0, 2) +: 8] = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h7F;
    return v;
  endfunction

  initial begin
    bit          seen;
    logic [2:0]  prev_c;
    logic [2:0]  c;
    logic [23:0] v;
    int          n;

    // Reset with red on the bus; report lands on the 5th edge after release
    apply_reset(24'hFF0000);
    hold(24'hFF0000, 1'b0, 4);
    chk("before_5th", {31'd0, out_valid}, 0);
    step(24'hFF0000, 1'b0);
    chk("rise_5th", {31'd0, out_valid}, 1);
    chk("red_colour", {29'd0, colour}, 3'b100);
    chk("red_err", {31'd0, code_err}, 0);

    // Handshake: green held back for 10 cycles, then accepted once
    apply_reset(24'h00FF00);
    hold(24'h00FF00, 1'b0, 15);
    chk("green_frozen", {29'd0, colour}, 3'b010);
    step(24'h00FF00, 1'b1);
    chk("green_accept_cnt", {24'd0, report_cnt}, 1);
    chk("green_accept_low", {31'd0, out_valid}, 0);
    for (int i = 0; i < 8; i++) step(24'h00FF00, 1'($urandom_range(0, 1)));
    chk("green_no_repeat", {24'd0, report_cnt}, 1);

    // Glitch filter: values alternating every 3 cycles never report
    seen = 0;
    for (int k = 0; k < 24; k++) begin
      step(((k / 3) % 2 != 0) ? 24'hFFFF00 : 24'h0000FF, 1'b0);
      if (out_valid) seen = 1;
    end
    chk("glitch_quiet", {31'd0, seen}, 0);
    hold(24'hFFFFFF, 1'b0, 5);
    chk("white_colour", {29'd0, colour}, 3'b111);
    chk("white_flag", {31'd0, is_white}, 1);
    step(24'hFFFFFF, 1'b1);

    // Illegal byte in the red channel
    hold(24'h80FF00, 1'b0, 5);
    chk("illegal_valid", {31'd0, out_valid}, 1);
`ifdef LIGHT_DECODER_THRESHOLD_EN
    chk("illegal_colour", {29'd0, colour}, 3'b110);
    chk("illegal_err", {31'd0, code_err}, 0);
`else
    chk("illegal_colour", {29'd0, colour}, 3'b000);
    chk("illegal_err", {31'd0, code_err}, 1);
`endif
    chk("illegal_white", {31'd0, is_white}, 0);
    step(24'h80FF00, 1'b1);

    // Overrun: cyan pending while magenta qualifies, magenta follows
    hold(24'h00FFFF, 1'b0, 5);
    chk("cyan_colour", {29'd0, colour}, 3'b011);
    hold(24'hFF00FF, 1'b0, 6);
    chk("overrun_set", {31'd0, overrun}, 1);
    step(24'hFF00FF, 1'b1);
    chk("cyan_accepted_gap", {31'd0, out_valid}, 0);
    step(24'hFF00FF, 1'b0);
    chk("magenta_next", {31'd0, out_valid}, 1);
    chk("magenta_colour", {29'd0, colour}, 3'b101);
    step(24'hFF00FF, 1'b1);

    // Counter wrap: keep reporting distinct codes until the count rolls to 0
    prev_c = 3'b101;
    for (int it = 0; it < 600 && m_cnt != 0; it++) begin
      c = 3'($urandom_range(0, 7));
      if (c == prev_c) c = c + 3'd1;
      prev_c = c;
      v = code_to_light(c);
      hold(v, 1'b0, 5 + $urandom_range(0, 2));
      step(v, 1'b1);
    end
    chk("wrap_cnt", {24'd0, report_cnt}, 0);
    chk("overrun_sticky", {31'd0, overrun}, 1);

    // Randomized bus activity and consumer back-pressure
    for (int seg = 0; seg < 150; seg++) begin
      v = pick_light();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) step(v, 1'($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset while a report is pending
    hold(24'h0000FF, 1'b0, 6);
    hold(24'hFF0000, 1'b0, 6);
    chk("pre_reset_hold", {31'd0, out_valid}, 1);
    #3 rst = 1'b0;
    #1 model_reset();
    chk("midhold_valid", {31'd0, out_valid}, 0);
    chk("midhold_cnt", {24'd0, report_cnt}, 0);
    chk("midhold_overrun", {31'd0, overrun}, 0);
    chk("midhold_state", {31'd0, fsm_state_o}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    hold(24'h0000FF, 1'b1, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/light_decoder.md
Name: light_decoder

Overview:
- Inverse of the colour-code-to-RGB conversion path: watches a 24-bit RGB light bus and recovers the 3-bit colour code, with white flagged separately.
- Sits downstream of the lights selector output, e.g. for self-check or status reporting.
- Filters transients with a stability window and reports each new stable colour once, over a valid/ready handshake.
- Counts accepted reports and flags malformed codes and missed updates.

Parameters:
STABLE_CYCLES, 4, consecutive unchanged cycles required before a value qualifies (legal range 1..255)
CNT_W, 8, width of the report counter

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous active-low reset
light  input  24  RGB bus {R[23:16],G[15:8],B[7:0]}
out_ready  input  1  consumer accepts the report when high while out_valid is high
out_valid  output  1  report pending
colour  output  3  recovered code {R,G,B}, one bit per channel
is_white  output  1  colour==3'b111 and the code is valid
code_err  output  1  held value is not a legal code
overrun  output  1  sticky: a new stable value qualified while a report was pending
report_cnt  output  CNT_W  number of accepted reports, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs go to 0.
  - Stability counter goes to 0.
  - "Last reported" register is marked empty.
  - FSM enters WAIT.
- Input stage: light is registered into light_q on every clock.
- Classification of light_q, per channel byte:
  - 8'hFF gives bit 1.
  - 8'h00 gives bit 0.
  - Any other byte is illegal: code_err=1 and colour=3'b000 for that report.
- Stability counter:
  - Cleared when light differs from light_q.
  - Otherwise increments, saturating at STABLE_CYCLES.
  - A value qualifies when the counter equals STABLE_CYCLES.
  - Latency: out_valid rises on the (STABLE_CYCLES+1)th rising edge after light takes a new value and holds it.
- FSM states: WAIT and HOLD.
  - WAIT to HOLD: when a value qualifies and either "last reported" is empty or the value differs from it.
    - Load colour, is_white and code_err.
    - Store the raw 24-bit value as "last reported".
    - Assert out_valid.
  - A qualified value equal to "last reported" never produces a second report.
  - In HOLD, out_valid, colour, is_white and code_err are frozen until out_valid and out_ready are both high on a clock edge.
  - On that acceptance edge: report_cnt increments, wrapping, and the FSM returns to WAIT with out_valid low on the next cycle.
  - Minimum gap between reports: 1 cycle.
  - If a value qualifies during HOLD and differs from the held value, overrun sets. It clears only on reset.
  - The stability counter keeps running during HOLD. After return to WAIT, a still-qualified new value is reported on the first WAIT cycle.
- Simultaneous events: out_ready arriving on the same edge that out_valid first rises has no effect. Acceptance needs out_valid already high.
- Reset mid-HOLD drops the pending report. The report is not counted.
- out_ready while out_valid is low is ignored.

Optional Feature:
- Macro: LIGHT_DECODER_THRESHOLD_EN.
- Defined: each channel bit is byte[7], i.e. byte >= 8'h80 gives 1. code_err is tied to 0. Any 24-bit value decodes.
- Not defined: exact 00/FF matching with code_err as described above.

Test Plan:
- Reset: hold rst low, drive light=24'hFF0000 -> all outputs 0. Release rst and hold the value with STABLE_CYCLES=4 -> out_valid rises on the 5th edge after release, colour=3'b100, code_err=0.
- Handshake: value 24'h00FF00 pending, out_ready low for 10 cycles -> outputs frozen. Raise out_ready -> report_cnt 0->1 and out_valid low the next cycle. Keep light unchanged -> no further report.
- Glitch filter: alternate 24'h0000FF and 24'hFFFF00 every 3 cycles (STABLE_CYCLES=4) -> out_valid never rises. Then hold 24'hFFFFFF -> colour=3'b111, is_white=1.
- Illegal code: light=24'h80FF00 held -> code_err=1, colour=3'b000, is_white=0. With LIGHT_DECODER_THRESHOLD_EN defined -> colour=3'b110, code_err=0.
- Overrun and wrap: report 24'h00FFFF, keep out_ready low, change to 24'hFF00FF for 6 cycles -> overrun=1. After acceptance -> magenta (3'b101) reported next. Run 256 accepted reports -> report_cnt wraps to 0.
- Async reset mid-HOLD: pull rst low between clock edges -> out_valid=0 immediately, report_cnt unchanged at its reset value 0, overrun=0.
